// File: rtl/sprite_pkg.sv
// sprite_pkg: shared constants and types for the sprite ROM arbiter.
//   N_REQ_DEF / ADDR_W_DEF / DATA_W_DEF : default build sizes
//   ID_W                                : requester id width (covers up to 4 requesters)
//   REQ_*                               : requester index assignment
//   tag_t                               : {valid, id} carried alongside each in-flight ROM read
package sprite_pkg;

  localparam int N_REQ_DEF  = 4;
  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 8;
  localparam int ID_W       = 2;

  localparam logic [ID_W-1:0] REQ_DOODLER = 2'd0;
  localparam logic [ID_W-1:0] REQ_MONSTER = 2'd1;
  localparam logic [ID_W-1:0] REQ_TOOL    = 2'd2;
  localparam logic [ID_W-1:0] REQ_BULLET  = 2'd3;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant search with fixed-priority override.
//   clk, rst_n : clock, async active-low reset
//   req        : per-requester level request
//   pri_en     : override enable; pri_id wins when it is requesting
//   pri_id     : override requester (ignored when >= N_REQ)
//   gnt        : one-hot grant, combinational
//   gnt_vld    : a grant is being issued this cycle
//   gnt_id     : index of the granted requester
module rr_arbiter
  import sprite_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             pri_en,
  input  logic [ID_W-1:0]  pri_id,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_vld,
  output logic [ID_W-1:0]  gnt_id
);

  logic [ID_W-1:0] rr_ptr;
  logic            hit;
  logic [ID_W-1:0] hit_id;
  logic [ID_W-1:0] scan_idx;
  logic            pri_hit;

  assign pri_hit = pri_en && (int'(pri_id) < N_REQ) && req[pri_id];

  // Rotating search: first requester at or after rr_ptr, wrapping.
  always_comb begin
    hit      = 1'b0;
    hit_id   = '0;
    scan_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx = ID_W'((int'(rr_ptr) + k) % N_REQ);
      if (!hit && req[scan_idx]) begin
        hit    = 1'b1;
        hit_id = scan_idx;
      end
    end
  end

  // Grant is forced low while in reset so every output reads zero.
  always_comb begin
    gnt_vld = rst_n && (pri_hit || hit);
    gnt_id  = pri_hit ? pri_id : hit_id;
    gnt     = '0;
    if (gnt_vld) gnt[gnt_id] = 1'b1;
  end

  // Override grants also move the pointer so the others are not starved.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       rr_ptr <= '0;
    else if (gnt_vld) rr_ptr <= (int'(gnt_id) == N_REQ - 1) ? '0 : gnt_id + 1'b1;
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter: shares one single-port sprite ROM among the sprite fetchers.
//   Clk, Reset_n : 50 MHz system clock, async active-low reset
//   req, addr    : per-requester level request and address (slice i for req[i])
//   pri_en/pri_id: fixed-priority override
//   gnt          : one-hot grant, combinational in the request cycle
//   rom_addr/rden: registered ROM address / read enable
//   rom_q        : ROM data, valid ROM_LAT cycles after the registered address
//   rd_valid     : registered one-hot return strobe; rd_data qualified by it
//   busy         : any read in flight
module sprite_rom_arbiter
  import sprite_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ROM_LAT = 2            // legal 1..4
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] addr,
  input  logic                    pri_en,
  input  logic [ID_W-1:0]         pri_id,
  output logic [N_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]       rom_addr,
  output logic                    rom_rden,
  input  logic [DATA_W-1:0]       rom_q,
  output logic [N_REQ-1:0]        rd_valid,
  output logic [DATA_W-1:0]       rd_data,
  output logic                    busy
);

  logic [N_REQ-1:0][ADDR_W-1:0] addr_v;
  logic                         gnt_vld;
  logic [ID_W-1:0]              gnt_id;
  tag_t [ROM_LAT:0]             tag_pipe;

  assign addr_v = addr;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk     (Clk),
    .rst_n   (Reset_n),
    .req     (req),
    .pri_en  (pri_en),
    .pri_id  (pri_id),
    .gnt     (gnt),
    .gnt_vld (gnt_vld),
    .gnt_id  (gnt_id)
  );

  // Issue: rom_addr holds its last value when nothing is granted.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rom_addr <= '0;
      rom_rden <= 1'b0;
    end else begin
      rom_rden <= gnt_vld;
      if (gnt_vld) rom_addr <= addr_v[gnt_id];
    end
  end

  // Tag travels beside the read; the last stage lines up with rom_q.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      tag_pipe <= '0;
    end else begin
      tag_pipe[0] <= '{valid: gnt_vld, id: gnt_id};
      for (int k = 1; k <= ROM_LAT; k++) tag_pipe[k] <= tag_pipe[k-1];
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rd_valid <= '0;
      rd_data  <= '0;
    end else begin
      rd_valid <= '0;
      if (tag_pipe[ROM_LAT].valid) begin
        rd_valid <= N_REQ'(1) << tag_pipe[ROM_LAT].id;
        rd_data  <= rom_q;
      end
    end
  end

  always_comb begin
    busy = rom_rden;
    for (int k = 0; k <= ROM_LAT; k++) busy = busy | tag_pipe[k].valid;
  end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
module tb_sprite_rom_arbiter;
  import sprite_pkg::*;

  localparam int N   = 4;
  localparam int AW  = 16;
  localparam int DW  = 8;
  localparam int LAT = 2;

  logic Clk = 1'b0;
  logic Reset_n;
  always #10 Clk = ~Clk;

  // main DUT (ROM_LAT=2)
  logic [N-1:0]    req;
  logic [N*AW-1:0] addr;
  logic            pri_en;
  logic [1:0]      pri_id;
  logic [N-1:0]    gnt;
  logic [AW-1:0]   rom_addr;
  logic            rom_rden;
  logic [DW-1:0]   rom_q;
  logic [N-1:0]    rd_valid;
  logic [DW-1:0]   rd_data;
  logic            busy;

  // second DUT (ROM_LAT=1)
  logic [N-1:0]    req1;
  logic [N*AW-1:0] addr1;
  logic            pri_en1;
  logic [1:0]      pri_id1;
  logic [N-1:0]    gnt1;
  logic [AW-1:0]   rom_addr1;
  logic            rom_rden1;
  logic [DW-1:0]   rom_q1;
  logic [N-1:0]    rd_valid1;
  logic [DW-1:0]   rd_data1;
  logic            busy1;

  sprite_rom_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(LAT)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .req(req), .addr(addr), .pri_en(pri_en), .pri_id(pri_id),
    .gnt(gnt), .rom_addr(rom_addr), .rom_rden(rom_rden), .rom_q(rom_q),
    .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy));

  sprite_rom_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(1)) dut1 (
    .Clk(Clk), .Reset_n(Reset_n), .req(req1), .addr(addr1), .pri_en(pri_en1), .pri_id(pri_id1),
    .gnt(gnt1), .rom_addr(rom_addr1), .rom_rden(rom_rden1), .rom_q(rom_q1),
    .rd_valid(rd_valid1), .rd_data(rd_data1), .busy(busy1));

  // ROM contents: 0x0123 -> 0x5A, 0xFFFF -> 0x78
  function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
    return a[15:8] ^ a[7:0] ^ 8'h78;
  endfunction

  // ROM models: data appears LAT cycles after the registered address
  logic [DW-1:0] rpipe [LAT];
  always @(posedge Clk) begin
    rpipe[0] <= rom_fn(rom_addr);
    for (int k = 1; k < LAT; k++) rpipe[k] <= rpipe[k-1];
  end
  assign rom_q = rpipe[LAT-1];

  logic [DW-1:0] rq1;
  always @(posedge Clk) rq1 <= rom_fn(rom_addr1);
  assign rom_q1 = rq1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    int            id;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t sbq[$];

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  logic [N-1:0] acc_g = '0;

  // Reference model: arbitration rules, issue, busy window; pushes expected returns.
  initial begin
    int            rr_m;
    int            last_g;
    logic [AW-1:0] exp_ra;
    int            gid;
    logic [N-1:0]  eg;
    logic [AW-1:0] a;
    rr_m = 0; last_g = -100; exp_ra = '0;
    forever begin
      @(negedge Clk);
      acc_g = gnt;
      if (!Reset_n) begin
        chk("rst_gnt", gnt, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_rom_rden", rom_rden, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_busy", busy, 0);
        rr_m = 0; last_g = -100; exp_ra = '0;
        sbq.delete();
      end else begin
        chk("rom_rden", rom_rden, last_g == cyc - 1);
        chk("rom_addr", rom_addr, exp_ra);
        chk("busy", busy, (cyc - last_g >= 1) && (cyc - last_g <= LAT + 1));
        gid = -1;
        if (pri_en && int'(pri_id) < N && req[pri_id]) gid = int'(pri_id);
        else
          for (int k = 0; k < N; k++)
            if (gid < 0 && req[(rr_m + k) % N]) gid = (rr_m + k) % N;
        eg = '0;
        if (gid >= 0) eg[gid] = 1'b1;
        chk("gnt", gnt, eg);
        if (gid >= 0) begin
          a = addr[gid*AW +: AW];
          sbq.push_back('{id: gid, data: rom_fn(a), due: cyc + LAT + 2});
          rr_m   = (gid + 1) % N;
          last_g = cyc;
          exp_ra = a;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT returns data.
  initial begin
    logic [DW-1:0] held;
    exp_t          e;
    held = '0;
    forever begin
      @(negedge Clk);
      if (!Reset_n) begin
        held = '0;
      end else if (rd_valid != '0) begin
        if (sbq.size() == 0) chk("spurious_rd_valid", rd_valid, 0);
        else begin
          e = sbq.pop_front();
          chk("rd_valid", rd_valid, N'(1) << e.id);
          chk("rd_data", rd_data, e.data);
          chk("rd_cycle", cyc, e.due);
          held = e.data;
        end
      end else begin
        chk("rd_hold", rd_data, held);
        if (sbq.size() > 0) chk("rd_missing", sbq[0].due > cyc, 1);
      end
    end
  end

  // One random cycle: granted requesters may re-request with a new address,
  // pending ones hold (or drop), idle ones may raise.
  task automatic drive_cycle(input int raise_pct, input int drop_pct);
    @(posedge Clk); #1;
    for (int i = 0; i < N; i++) begin
      if (acc_g[i] || !req[i]) begin
        if (int'($urandom_range(99)) < raise_pct) begin
          req[i] = 1'b1;
          addr[i*AW +: AW] = AW'($urandom);
        end else req[i] = 1'b0;
      end else if (int'($urandom_range(99)) < drop_pct) req[i] = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge Clk); #1; req = '0; pri_en = 1'b0; end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_n = 1'b0; req = '0; addr = '0; pri_en = 1'b0; pri_id = '0;
    req1 = '0; addr1 = '0; pri_en1 = 1'b0; pri_id1 = '0;
    repeat (3) @(posedge Clk);
    #1 Reset_n = 1'b1;
    idle(2);

    // single read from the doodler, ROM returns 0x5A
    @(posedge Clk); #1; req = 4'b0001; addr[0 +: AW] = 16'h0123;
    @(posedge Clk); #1; req = '0;
    idle(6);

    // ROM_LAT=1 build, bullet at 0xFFFF
    @(posedge Clk); #1; req1 = 4'b1000; addr1[int'(REQ_BULLET)*AW +: AW] = 16'hFFFF;
    @(negedge Clk); chk("lat1_gnt", gnt1, 4'b1000);
    @(posedge Clk); #1; req1 = '0;
    @(negedge Clk); chk("lat1_rom_addr", rom_addr1, 16'hFFFF);
                    chk("lat1_rom_rden", rom_rden1, 1);
                    chk("lat1_busy", busy1, 1);
    @(negedge Clk); chk("lat1_rd_valid_t2", rd_valid1, 0);
    @(negedge Clk); chk("lat1_rd_valid_t3", rd_valid1, 4'b1000);
                    chk("lat1_rd_data", rd_data1, 8'h78);
    @(negedge Clk); chk("lat1_rd_valid_t4", rd_valid1, 0);

    // all four requesting for 8 cycles, round robin
    for (int i = 0; i < N; i++) addr[i*AW +: AW] = AW'($urandom);
    @(posedge Clk); #1; req = '1;
    repeat (7) drive_cycle(100, 0);
    idle(6);

    // override to the tool for 4 cycles, then back to round robin
    @(posedge Clk); #1; req = '1; pri_en = 1'b1; pri_id = REQ_TOOL;
    repeat (3) drive_cycle(100, 0);
    drive_cycle(100, 0); pri_en = 1'b0;
    drive_cycle(100, 0);
    idle(6);

    // three grants then reset mid-flight
    @(posedge Clk); #1; req = 4'b0001; addr[0 +: AW] = 16'h1111;
    @(posedge Clk); #1; req = 4'b0010; addr[1*AW +: AW] = 16'h2222;
    @(posedge Clk); #1; req = 4'b0100; addr[2*AW +: AW] = 16'h3333;
    @(posedge Clk); #1; req = '0; Reset_n = 1'b0;
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1'b1;
    idle(6);

    // monster pulses for one cycle while the doodler is granted
    @(posedge Clk); #1; req = 4'b0011; addr[0 +: AW] = 16'h0A0A; addr[1*AW +: AW] = 16'h0B0B;
    @(posedge Clk); #1; req = '0;
    idle(6);

    // random traffic with occasional override
    for (int c = 0; c < 400; c++) begin
      drive_cycle(60, 15);
      if ($urandom_range(9) == 0) begin
        pri_en = ($urandom_range(1) == 1);
        pri_id = 2'($urandom_range(3));
      end
    end
    idle(8);
    chk("drain", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_rom_arbiter.md
Name: sprite_rom_arbiter

Overview:
- Shares one single-port on-chip sprite ROM among the per-pixel sprite fetchers: doodler, monster, tool/spring and bullet.
- Sits between those fetchers and the ROM, on the 50 MHz system clock, upstream of the color mapper.
- Grants one read per cycle using round-robin arbitration, with an optional fixed-priority override.
- Tags each in-flight read so the returned data reaches only the requester that issued it.

Parameters:
- N_REQ, 4, number of requesters (index 0 = doodler, 1 = monster, 2 = tool, 3 = bullet).
- ADDR_W, 16, sprite ROM address width.
- DATA_W, 8, ROM word width (palette index).
- ROM_LAT, 2, ROM read latency in cycles, from registered address to valid rom_q; legal range 1..4.

Ports:
- Clk  in  1  system clock (50 MHz).
- Reset_n  in  1  asynchronous active-low reset.
- req  in  N_REQ  per-requester read request, level.
- addr  in  N_REQ*ADDR_W  per-requester address; slice i belongs to req[i].
- pri_en  in  1  enable fixed-priority override.
- pri_id  in  2  requester that wins unconditionally when pri_en=1 and req[pri_id]=1.
- gnt  out  N_REQ  one-hot grant, combinational in the request cycle.
- rom_addr  out  ADDR_W  registered ROM address.
- rom_rden  out  1  registered ROM read enable.
- rom_q  in  DATA_W  ROM read data.
- rd_valid  out  N_REQ  one-hot return strobe, registered.
- rd_data  out  DATA_W  returned word, registered; qualified by rd_valid.
- busy  out  1  high while any read is in flight.

Behaviour:
- Reset (async assert, sync release): gnt=0, rom_addr=0, rom_rden=0, rd_valid=0, rd_data=0, busy=0, rr pointer=0, tag pipeline cleared.
- Arbitration, cycle t:
  - If pri_en=1 and req[pri_id]=1, grant pri_id.
  - Otherwise grant the first requester with req=1, searching from rr_ptr upward and wrapping modulo N_REQ.
  - If no req is high, gnt=0.
- Handshake:
  - A read is accepted on the rising edge that ends a cycle where gnt[i]=1.
  - A requester holds req and addr stable until it sees gnt.
  - Dropping req before gnt is legal; the request is simply withdrawn.
- rr_ptr:
  - On each accepted grant to i, rr_ptr <= (i+1) mod N_REQ.
  - Priority-override grants also advance rr_ptr, so other requesters are not starved.
  - rr_ptr is unchanged when there is no grant.
- Issue: at the accepting edge, rom_addr <= addr[i] and rom_rden <= 1. With no grant, rom_rden <= 0 and rom_addr holds its value.
- Tag pipeline:
  - ROM_LAT+1 stages, each holding {valid, id}; stage 0 is loaded at the accepting edge.
  - When the final stage is valid, rd_data <= rom_q and rd_valid <= onehot(id) at the next edge.
  - Total latency: grant cycle t to rd_valid high in cycle t+ROM_LAT+2. With ROM_LAT=2, that is t+4.
- Throughput: one grant per cycle, sustained. Back-to-back grants return back-to-back, in grant order.
- rd_valid: high for exactly one cycle per accepted read. rd_data holds its value when rd_valid=0.
- busy: OR of all tag-stage valids and rom_rden.
- Simultaneous events: a new grant and a data return in the same cycle are independent; no stall exists.
- Reset mid-operation: all in-flight reads are discarded and no rd_valid is emitted for them afterwards.
- pri_id >= N_REQ: the override is ignored and round-robin applies.

Decomposition:
- Package sprite_pkg holds N_REQ and ADDR_W/DATA_W defaults.
- It also holds the requester ID constants REQ_DOODLER=0, REQ_MONSTER=1, REQ_TOOL=2, REQ_BULLET=3, and a typedef for the tag struct {valid, id}.
- One sub-module, rr_arbiter: the combinational rotate/priority search plus the rr_ptr register.
- The tag pipeline and output registers stay in sprite_rom_arbiter.

Test Plan:
- Reset, then req=4'b0001 with addr0=16'h0123 at t=0:
  - gnt=0001 at t0.
  - rom_addr=0123 and rom_rden=1 at t1.
  - ROM model returns 8'h5A; rd_valid=0001 and rd_data=5A at t4.
  - busy falls at t4.
- All four req held high for 8 cycles, pri_en=0: gnt sequence 0001,0010,0100,1000,0001,...; each requester sees returns in grant order.
- pri_en=1, pri_id=2, all req high for 4 cycles: gnt=0100 every cycle, and rr_ptr=3 after the first grant. Then pri_en=0: next gnt=1000.
- req[1] pulsed for one cycle while req[0] is granted: gnt[1] is never asserted, rd_valid[1] never fires, and rd_valid[0] fires exactly once.
- Three grants at t0..t2, Reset_n asserted low at t3 and released at t5: no rd_valid is observed from t3 onward, and all outputs are 0 during reset.
- ROM_LAT=1 build, single req[3] at addr 16'hFFFF: rd_valid=1000 at t+3, and rom_addr=FFFF.
